// File: rtl/qtu_pkg.sv
// Shared types for the Q-table-update / find-my-best neighbor table.
// The age field exists only when QTU_AGING_EN is defined.
package qtu_pkg;

    localparam int QTU_WW    = 16;
    localparam int QTU_AGE_W = 4;

    typedef struct packed {
        logic [QTU_WW-1:0] id;
        logic [QTU_WW-1:0] hops;
        logic [QTU_WW-1:0] qval;
        logic [QTU_WW-1:0] energy;
        logic [QTU_WW-1:0] hopsCH;
        logic              valid;
`ifdef QTU_AGING_EN
        logic [QTU_AGE_W-1:0] age;
`endif
    } nbr_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_WRITE,
        S_SCAN,
        S_DONE
    } qtu_state_e;

    localparam logic [QTU_WW-1:0] HOPS_INVALID = '1;

endpackage

// File: rtl/qtu_best_cmp.sv
// Next-hop ordering: fewer hops to CH, then larger Q, then smaller ID.
// Purely combinational.
module qtu_best_cmp #(
    parameter int W = 16
) (
    input  logic [W-1:0] cand_hops,
    input  logic [W-1:0] cand_q,
    input  logic [W-1:0] cand_id,
    input  logic [W-1:0] best_hops,
    input  logic [W-1:0] best_q,
    input  logic [W-1:0] best_id,
    output logic         beats
);

    always_comb begin
        beats = 1'b0;
        if (cand_hops < best_hops)
            beats = 1'b1;
        else if (cand_hops == best_hops) begin
            if (cand_q > best_q)
                beats = 1'b1;
            else if (cand_q == best_q && cand_id < best_id)
                beats = 1'b1;
        end
    end

endmodule

// File: rtl/qtu_neighbor_table.sv
// Neighbor table with insert/update by ID, heartbeat flush and best-next-hop scan.
// Define QTU_AGING_EN to age entries on heartbeat instead of flushing them.
module qtu_neighbor_table
    import qtu_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_NBR    = 32,
    parameter int AGE_MAX    = 3
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic [WORD_WIDTH-1:0]        fSourceID,
    input  logic [WORD_WIDTH-1:0]        fSourceHops,
    input  logic [WORD_WIDTH-1:0]        fQValue,
    input  logic [WORD_WIDTH-1:0]        fEnergyLeft,
    input  logic [WORD_WIDTH-1:0]        fHopsFromCH,
    input  logic [WORD_WIDTH-1:0]        fChosenCH,
    input  logic [WORD_WIDTH-1:0]        chosenCH,
    input  logic [WORD_WIDTH-1:0]        hopsFromCH,
    input  logic                         fmb_req,
    input  logic                         hb_reset,
    output logic [WORD_WIDTH-1:0]        nextHop,
    output logic [WORD_WIDTH-1:0]        nextHopCount,
    output logic                         nextHopValid,
    output logic [$clog2(NUM_NBR+1)-1:0] neighborCount,
    output logic                         tbl_drop,
    output logic                         done
);

    localparam int IW = $clog2(NUM_NBR);
    localparam int CW = $clog2(NUM_NBR+1);
    localparam logic [IW-1:0] LAST = IW'(NUM_NBR-1);

    nbr_entry_t tbl [NUM_NBR];
    nbr_entry_t cur;
    nbr_entry_t wr_e;
    qtu_state_e state, state_n;

    logic [IW-1:0]         idx;
    logic                  pending;
    logic [WORD_WIDTH-1:0] u_id, u_hops, u_q, u_en, u_hch;
    logic                  u_match;
    logic                  hit_found, free_found;
    logic [IW-1:0]         hit_idx, free_idx;
    logic [WORD_WIDTH-1:0] my_hops;
    logic                  best_found;
    logic [WORD_WIDTH-1:0] best_id, best_hops, best_q;
    logic                  cand, beats;
    logic                  unused_fields;

    assign cur  = tbl[idx];
    assign cand = cur.valid && (cur.hopsCH < my_hops);
    assign unused_fields = ^{cur.hops, cur.energy};

    qtu_best_cmp #(.W(WORD_WIDTH)) u_cmp (
        .cand_hops (cur.hopsCH),
        .cand_q    (cur.qval),
        .cand_id   (cur.id),
        .best_hops (best_hops),
        .best_q    (best_q),
        .best_id   (best_id),
        .beats     (beats)
    );

    always_comb begin
        wr_e        = '0;
        wr_e.id     = u_id;
        wr_e.hops   = u_hops;
        wr_e.qval   = u_q;
        wr_e.energy = u_en;
        wr_e.hopsCH = u_hch;
        wr_e.valid  = 1'b1;
    end

`ifdef QTU_AGING_EN
    logic [NUM_NBR-1:0] evict;
    logic [CW-1:0]      n_evict;
    logic               hop_evicted;

    // An entry dies on the heartbeat that would take its age to AGE_MAX.
    always_comb begin
        evict       = '0;
        n_evict     = '0;
        hop_evicted = 1'b0;
        for (int i = 0; i < NUM_NBR; i++) begin
            evict[i] = tbl[i].valid && (int'(tbl[i].age) + 1 >= AGE_MAX);
            if (evict[i]) begin
                n_evict = n_evict + CW'(1);
                if (nextHopValid && tbl[i].id == nextHop)
                    hop_evicted = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (upd_valid)
                    state_n = S_SEARCH;
                else if (pending || fmb_req)
                    state_n = S_SCAN;
            end
            S_SEARCH: if (idx == LAST) state_n = S_WRITE;
            S_WRITE:  state_n = S_IDLE;
            S_SCAN:   if (idx == LAST) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (hb_reset)
            state_n = S_IDLE;
    end

    assign upd_ready = (state == S_IDLE) && !hb_reset;
    assign done = !hb_reset && (state == S_WRITE || state == S_DONE);
    assign tbl_drop = !hb_reset && (state == S_WRITE) && u_match
                      && !hit_found && !free_found;

    always_ff @(posedge clk) begin
        if (nrst) begin
            state         <= S_IDLE;
            idx           <= '0;
            pending       <= 1'b0;
            nextHop       <= '0;
            nextHopCount  <= '1;
            nextHopValid  <= 1'b0;
            neighborCount <= '0;
            u_id          <= '0;
            u_hops        <= '0;
            u_q           <= '0;
            u_en          <= '0;
            u_hch         <= '0;
            u_match       <= 1'b0;
            hit_found     <= 1'b0;
            free_found    <= 1'b0;
            hit_idx       <= '0;
            free_idx      <= '0;
            my_hops       <= '0;
            best_found    <= 1'b0;
            best_id       <= '0;
            best_hops     <= HOPS_INVALID;
            best_q        <= '0;
            for (int i = 0; i < NUM_NBR; i++)
                tbl[i] <= '0;
        end else if (hb_reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            pending <= 1'b0;
`ifdef QTU_AGING_EN
            for (int i = 0; i < NUM_NBR; i++) begin
                if (evict[i])
                    tbl[i].valid <= 1'b0;
                else if (tbl[i].valid)
                    tbl[i].age <= tbl[i].age + 1'b1;
            end
            neighborCount <= neighborCount - n_evict;
            if (hop_evicted)
                nextHopValid <= 1'b0;
`else
            for (int i = 0; i < NUM_NBR; i++)
                tbl[i].valid <= 1'b0;
            neighborCount <= '0;
            nextHopValid  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == S_IDLE && state_n == S_SCAN)
                pending <= 1'b0;
            else if (fmb_req)
                pending <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (upd_valid) begin
                        u_id       <= fSourceID;
                        u_hops     <= fSourceHops;
                        u_q        <= fQValue;
                        u_en       <= fEnergyLeft;
                        u_hch      <= fHopsFromCH;
                        u_match    <= (fChosenCH == chosenCH);
                        hit_found  <= 1'b0;
                        free_found <= 1'b0;
                    end else if (pending || fmb_req) begin
                        my_hops    <= hopsFromCH;
                        best_found <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                    if (!hit_found && cur.valid && cur.id == u_id) begin
                        hit_found <= 1'b1;
                        hit_idx   <= idx;
                    end
                    if (!free_found && !cur.valid) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                end
                S_WRITE: begin
                    if (u_match) begin
                        if (hit_found)
                            tbl[hit_idx] <= wr_e;
                        else if (free_found) begin
                            tbl[free_idx] <= wr_e;
                            neighborCount <= neighborCount + CW'(1);
                        end
                    end
                end
                S_SCAN: begin
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                    if (cand && (!best_found || beats)) begin
                        best_found <= 1'b1;
                        best_id    <= cur.id;
                        best_hops  <= cur.hopsCH;
                        best_q     <= cur.qval;
                    end
                end
                S_DONE: begin
                    // A node one hop from its CH always forwards to the CH.
                    if (my_hops == WORD_WIDTH'(1)) begin
                        nextHop      <= chosenCH;
                        nextHopCount <= '0;
                        nextHopValid <= 1'b1;
                    end else if (best_found) begin
                        nextHop      <= best_id;
                        nextHopCount <= best_hops;
                        nextHopValid <= 1'b1;
                    end else
                        nextHopValid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qtu_neighbor_table.sv
// Directed bench for qtu_neighbor_table with a small table (8 entries).
// Aging checks run only when QTU_AGING_EN is defined.
module tb_qtu_neighbor_table;

    localparam int WW = 16;
    localparam int NN = 8;
`ifdef QTU_AGING_EN
    localparam int AM = 2;
`else
    localparam int AM = 3;
`endif
    localparam int CW = $clog2(NN+1);

    logic          clk = 1'b0;
    logic          nrst;
    logic          upd_valid;
    logic          upd_ready;
    logic [WW-1:0] fSourceID, fSourceHops, fQValue, fEnergyLeft;
    logic [WW-1:0] fHopsFromCH, fChosenCH, chosenCH, hopsFromCH;
    logic          fmb_req, hb_reset;
    logic [WW-1:0] nextHop, nextHopCount;
    logic          nextHopValid;
    logic [CW-1:0] neighborCount;
    logic          tbl_drop, done;

    int n_chk  = 0;
    int n_fail = 0;

    qtu_neighbor_table #(
        .WORD_WIDTH(WW), .NUM_NBR(NN), .AGE_MAX(AM)
    ) dut (
        .clk(clk), .nrst(nrst),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .fSourceID(fSourceID), .fSourceHops(fSourceHops),
        .fQValue(fQValue), .fEnergyLeft(fEnergyLeft),
        .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH),
        .chosenCH(chosenCH), .hopsFromCH(hopsFromCH),
        .fmb_req(fmb_req), .hb_reset(hb_reset),
        .nextHop(nextHop), .nextHopCount(nextHopCount),
        .nextHopValid(nextHopValid), .neighborCount(neighborCount),
        .tbl_drop(tbl_drop), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat, output logic drop);
        lat = 1;
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
        drop = tbl_drop;
        tick();
    endtask

    task automatic upd(input logic [WW-1:0] id, input logic [WW-1:0] q,
                       input logic [WW-1:0] hch, input logic [WW-1:0] fch,
                       output int lat, output logic drop);
        upd_valid   = 1'b1;
        fSourceID   = id;
        fSourceHops = id + 16'd1;
        fQValue     = q;
        fEnergyLeft = 16'h0100;
        fHopsFromCH = hch;
        fChosenCH   = fch;
        tick();
        upd_valid = 1'b0;
        wait_done(lat, drop);
    endtask

    task automatic fmb(output int lat);
        logic d;
        fmb_req = 1'b1;
        tick();
        fmb_req = 1'b0;
        wait_done(lat, d);
    endtask

    task automatic hb();
        hb_reset = 1'b1;
        tick();
        hb_reset = 1'b0;
    endtask

    initial begin
        int   lat;
        logic drop;
        logic seen;

        nrst = 1'b1;
        upd_valid = 1'b0; fmb_req = 1'b0; hb_reset = 1'b0;
        fSourceID = '0; fSourceHops = '0; fQValue = '0; fEnergyLeft = '0;
        fHopsFromCH = '0; fChosenCH = '0;
        chosenCH = 16'd100; hopsFromCH = 16'd2;
        tick(); tick();
        nrst = 1'b0;

        check("rst_nexthop", 32'(nextHop), 32'h0);
        check("rst_nhcount", 32'(nextHopCount), 32'hffff);
        check("rst_nhvalid", 32'(nextHopValid), 32'h0);
        check("rst_count", 32'(neighborCount), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_drop", 32'(tbl_drop), 32'h0);
        check("rst_ready", 32'(upd_ready), 32'h1);

        upd(16'd5, 16'd20, 16'd1, 16'd100, lat, drop);
        check("ins5_lat", 32'(lat), 32'(NN+1));
        upd(16'd9, 16'd5, 16'd1, 16'd100, lat, drop);
        check("ins9_lat", 32'(lat), 32'(NN+1));
        upd(16'd3, 16'd10, 16'd1, 16'd100, lat, drop);
        check("ins3_lat", 32'(lat), 32'(NN+1));
        check("ins_count", 32'(neighborCount), 32'd3);
        check("done_low", 32'(done), 32'h0);

        upd(16'd9, 16'h40, 16'd1, 16'd100, lat, drop);
        check("upd9_count", 32'(neighborCount), 32'd3);
        fmb(lat);
        check("fmb_lat", 32'(lat), 32'(NN+1));
        check("fmb_q40_hop", 32'(nextHop), 32'd9);

        upd(16'd7, 16'd99, 16'd0, 16'd101, lat, drop);
        check("filt_lat", 32'(lat), 32'(NN+1));
        check("filt_drop", 32'(drop), 32'h0);
        check("filt_count", 32'(neighborCount), 32'd3);

        upd(16'd9, 16'd20, 16'd1, 16'd100, lat, drop);
        fmb(lat);
        check("tie_hop", 32'(nextHop), 32'd5);
        check("tie_cnt", 32'(nextHopCount), 32'd1);
        check("tie_valid", 32'(nextHopValid), 32'h1);

        upd(16'd12, 16'd1, 16'd0, 16'd100, lat, drop);
        fmb(lat);
        check("hops_hop", 32'(nextHop), 32'd12);
        check("hops_cnt", 32'(nextHopCount), 32'd0);

        hopsFromCH = 16'd1;
        fmb(lat);
        check("ch1_lat", 32'(lat), 32'(NN+1));
        check("ch1_hop", 32'(nextHop), 32'd100);
        check("ch1_cnt", 32'(nextHopCount), 32'd0);
        check("ch1_valid", 32'(nextHopValid), 32'h1);

        hopsFromCH = 16'd0;
        fmb(lat);
        check("none_valid", 32'(nextHopValid), 32'h0);
        check("none_hop", 32'(nextHop), 32'd100);

        for (int i = 0; i < 4; i++)
            upd(16'(20 + i), 16'd7, 16'd5, 16'd100, lat, drop);
        check("full_count", 32'(neighborCount), 32'(NN));
        upd(16'd30, 16'd7, 16'd1, 16'd100, lat, drop);
        check("full_drop", 32'(drop), 32'h1);
        check("full_cnt2", 32'(neighborCount), 32'(NN));

        hopsFromCH = 16'd2;
        fmb(lat);
        check("pre_hb_hop", 32'(nextHop), 32'd12);
        check("pre_hb_val", 32'(nextHopValid), 32'h1);

        fmb_req = 1'b1;
        tick();
        fmb_req = 1'b0;
        tick(); tick();
        hb();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen = 1'b1;
            tick();
        end
        check("hb_no_done", 32'(seen), 32'h0);
`ifdef QTU_AGING_EN
        check("hb_age_cnt", 32'(neighborCount), 32'(NN));
        check("hb_age_val", 32'(nextHopValid), 32'h1);
        upd(16'd5, 16'd20, 16'd1, 16'd100, lat, drop);
        check("refresh_cnt", 32'(neighborCount), 32'(NN));
        hb();
        check("evict_cnt", 32'(neighborCount), 32'd1);
        check("evict_val", 32'(nextHopValid), 32'h0);
        fmb(lat);
        check("keep5_hop", 32'(nextHop), 32'd5);
        check("keep5_val", 32'(nextHopValid), 32'h1);
`else
        check("hb_count", 32'(neighborCount), 32'd0);
        check("hb_valid", 32'(nextHopValid), 32'h0);
        fmb(lat);
        check("empty_val", 32'(nextHopValid), 32'h0);
        upd(16'd9, 16'd3, 16'd1, 16'd100, lat, drop);
        check("reins_cnt", 32'(neighborCount), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
